// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser, PRESCALE-oversampled start/data/parity/stop framing.
// Optional build macro UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
module uart_rx #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic [2:0]            dbg_state
);
    localparam int CW = $clog2(PRESCALE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] EDGE_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] EDGE_MID  = CW'(PRESCALE / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  rx_meta_q, rx_meta_d;
    logic                  rx_s_q, rx_s_d;
    logic [CW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_fail_q, par_fail_d;
    logic                  smp_q, smp_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    logic sample_now;
    logic bit_val;
    logic cur_bit;
    logic end_bit;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] EDGE_EARLY = CW'(PRESCALE / 2 - 1);
    localparam logic [CW-1:0] EDGE_LATE  = CW'(PRESCALE / 2 + 1);

    // maj_q[0] holds the early sample, maj_q[1] the centre sample; rx_s is the late one.
    logic [1:0] maj_q, maj_d;

    assign sample_now = (state_q != S_IDLE) && (edge_q == EDGE_LATE);
    assign bit_val    = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);

    always_comb begin
        maj_d = maj_q;
        if (edge_q == EDGE_EARLY) maj_d[0] = rx_s_q;
        if (edge_q == EDGE_MID)   maj_d[1] = rx_s_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST) maj_q <= '0;
        else      maj_q <= maj_d;
    end
`else
    assign sample_now = (state_q != S_IDLE) && (edge_q == EDGE_MID);
    assign bit_val    = rx_s_q;
`endif

    // The decision sample can land on the last edge of a bit (PRESCALE=4 with majority).
    assign cur_bit = sample_now ? bit_val : smp_q;
    assign end_bit = (edge_q == EDGE_LAST);

    always_comb begin
        rx_meta_d  = RX_IN;
        rx_s_d     = rx_meta_q;
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;
        smp_d      = smp_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        pe_d       = 1'b0;
        se_d       = 1'b0;

        if (state_q != S_IDLE) begin
            edge_d = end_bit ? '0 : edge_q + CW'(1);
            if (sample_now) smp_d = bit_val;
        end

        case (state_q)
            S_IDLE: begin
                edge_d     = '0;
                bit_d      = '0;
                par_fail_d = 1'b0;
                if (!rx_s_q) begin
                    state_d   = S_START;
                    edge_d    = CW'(1);
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                end
            end
            S_START: begin
                if (end_bit) state_d = cur_bit ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample_now) shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                if (end_bit) begin
                    bit_d = bit_q + BW'(1);
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample_now && (bit_val != ((^shift_q) ^ par_typ_q))) par_fail_d = 1'b1;
                if (end_bit) state_d = S_STOP;
            end
            S_STOP: begin
                if (end_bit) begin
                    state_d = S_IDLE;
                    se_d    = ~cur_bit;
                    pe_d    = par_fail_q;
                    dv_d    = cur_bit & ~par_fail_q;
                    if (cur_bit && !par_fail_q) p_data_d = shift_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            edge_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_fail_q <= 1'b0;
            smp_q      <= 1'b0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_fail_q <= par_fail_d;
            smp_q      <= smp_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: builds a per-cycle pin stimulus, decodes it with a frame-level model,
// then replays it into the DUT and compares every cycle.
module tb_uart_rx;
    localparam int P    = 8;
    localparam int MAXC = 12000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    uart_rx #(.PRESCALE(P), .DATA_WIDTH(8)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .RX_IN     (rx_in),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .DATA_VALID(data_valid),
        .PAR_ERR   (par_err),
        .STP_ERR   (stp_err),
        .dbg_state (dbg_state)
    );

    // Pin values driven during cycle t (cycle t begins at the t-th rising edge).
    logic       rx_a  [MAXC];
    logic       rst_a [MAXC];
    logic       pe_a  [MAXC];
    logic       pt_a  [MAXC];
    logic       ex_dv [MAXC];
    logic       ex_pe [MAXC];
    logic       ex_se [MAXC];
    logic [7:0] ex_byte [MAXC];
    logic [7:0] ex_pd [MAXC];
    logic       ac_dv [MAXC];
    logic       ac_pe [MAXC];
    logic       ac_se [MAXC];
    logic [7:0] ac_pd [MAXC];
    logic [2:0] ac_st [MAXC];

    int   n_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic cur_pe = 1'b0;
    logic cur_pt = 1'b0;

    task automatic chk(input string name, input int t, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, t, got, exp);
    endtask

    task automatic put(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            if (n_cyc < MAXC) begin
                rx_a[n_cyc]  = b;
                rst_a[n_cyc] = 1'b1;
                pe_a[n_cyc]  = cur_pe;
                pt_a[n_cyc]  = cur_pt;
                n_cyc++;
            end
        end
    endtask

    task automatic frame(input logic [7:0] d, input logic pe, input logic pt, input logic par_flip,
                         input logic stop_v, input int inv_bit, input int rst_off);
        int s;
        s = n_cyc;
        cur_pe = pe;
        cur_pt = pt;
        put(1'b0, P);
        for (int k = 0; k < 8; k++) put(d[k], P);
        if (pe) put((^d) ^ pt ^ par_flip, P);
        put(stop_v, P);
        // Frame-format pins wander mid-frame; only the value at start detection matters.
        for (int c = s + 2 * P; c < s + 7 * P; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                pe_a[c] = 1'($urandom_range(0, 1));
                pt_a[c] = 1'($urandom_range(0, 1));
            end
        end
        if (inv_bit >= 0) rx_a[s + (inv_bit + 1) * P + P / 2] = ~rx_a[s + (inv_bit + 1) * P + P / 2];
        if (rst_off >= 0) rst_a[s + rst_off] = 1'b0;
    endtask

    // Reset takes effect in the cycle after RST is seen low.
    function automatic logic rz(input int t);
        if (t < 1) return 1'b1;
        if (t - 1 >= n_cyc) return 1'b0;
        return !rst_a[t - 1];
    endfunction

    function automatic logic rxs(input int t);
        if (t < 2) return 1'b1;
        if (rz(t) || rz(t - 1)) return 1'b1;
        if (t - 2 >= n_cyc) return 1'b1;
        return rx_a[t - 2];
    endfunction

    // Bit value of the bit whose centre cycle is c.
    function automatic logic bitv(input int c);
`ifdef UART_RX_MAJORITY_EN
        logic a, b, e;
        a = rxs(c - 1);
        b = rxs(c);
        e = rxs(c + 1);
        return (a & b) | (a & e) | (b & e);
`else
        return rxs(c);
`endif
    endfunction

    task automatic run_model();
        int t, t0, nb, fin, ab;
        logic fpe, fpt, pbit, stopb, pfail;
        logic [7:0] d, pd;
        for (int i = 0; i < MAXC; i++) begin
            ex_dv[i] = 1'b0; ex_pe[i] = 1'b0; ex_se[i] = 1'b0; ex_byte[i] = 8'h00;
        end
        t = 0;
        while (t < n_cyc) begin
            if (rz(t) || rxs(t)) begin
                t++;
                continue;
            end
            t0  = t;
            fpe = pe_a[t0];
            fpt = pt_a[t0];
            nb  = fpe ? 11 : 10;
            fin = bitv(t0 + P / 2) ? t0 + P : t0 + nb * P;
            ab  = -1;
            for (int c = t0 + 1; c <= fin; c++) if (ab < 0 && rz(c)) ab = c;
            if (ab >= 0) begin
                t = ab;
                continue;
            end
            if (fin == t0 + nb * P && fin < MAXC) begin
                for (int k = 0; k < 8; k++) d[k] = bitv(t0 + (k + 1) * P + P / 2);
                pbit  = bitv(t0 + 9 * P + P / 2);
                stopb = bitv(t0 + (nb - 1) * P + P / 2);
                pfail = fpe && (pbit != ((^d) ^ fpt));
                ex_pe[fin]   = pfail;
                ex_se[fin]   = !stopb;
                ex_dv[fin]   = stopb && !pfail;
                ex_byte[fin] = d;
            end
            t = fin;
        end
        pd = 8'h00;
        for (int i = 0; i < n_cyc; i++) begin
            if (rz(i)) pd = 8'h00;
            else if (ex_dv[i]) pd = ex_byte[i];
            ex_pd[i] = pd;
        end
    endtask

    int s1, s2, s3, s4, g, s81, s5, s6, s7;
    int inv7, cnt;

    initial begin
        put(1'b1, 4);
        for (int i = 0; i < 4; i++) rst_a[i] = 1'b0;
        put(1'b1, 6);
        s1 = n_cyc; frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1); put(1'b1, 4);
        s2 = n_cyc; frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1); put(1'b1, 4);
        s3 = n_cyc; frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1); put(1'b1, 4);
        s4 = n_cyc; frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1); put(1'b1, 4);
        g = n_cyc; put(1'b0, 3); put(1'b1, 5);
        s81 = n_cyc; frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1); put(1'b1, 4);
        s5 = n_cyc; frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, -1, 34); put(1'b1, 10);
        s6 = n_cyc; frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1); put(1'b1, 4);
`ifdef UART_RX_MAJORITY_EN
        inv7 = 2;
`else
        inv7 = -1;
`endif
        s7 = n_cyc; frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, inv7, -1);
        frame(8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, -1, -1); put(1'b1, 6);

        repeat (25) begin
            if ($urandom_range(0, 7) == 0) begin
                put(1'b0, $urandom_range(1, 3));
                put(1'b1, P);
            end
            frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 87)) : -1);
            put(1'b1, $urandom_range(0, 12));
        end
        put(1'b1, 200);

        run_model();

        fork
            begin
                for (int t = 0; t < n_cyc; t++) begin
                    @(negedge clk);
                    rx_in   = rx_a[t];
                    rst_n   = rst_a[t];
                    par_en  = pe_a[t];
                    par_typ = pt_a[t];
                end
            end
            begin
                for (int t = 0; t < n_cyc; t++) begin
                    @(posedge clk);
                    #1;
                    ac_dv[t] = data_valid;
                    ac_pe[t] = par_err;
                    ac_se[t] = stp_err;
                    ac_pd[t] = p_data;
                    ac_st[t] = dbg_state;
                    chk("data_valid", t, 32'(data_valid), 32'(ex_dv[t]));
                    chk("par_err", t, 32'(par_err), 32'(ex_pe[t]));
                    chk("stp_err", t, 32'(stp_err), 32'(ex_se[t]));
                    chk("p_data", t, 32'(p_data), 32'(ex_pd[t]));
                end
            end
        join

        // Hand-computed pins: T0 = frame start + 2 (synchroniser), strobe at T0 + 10*8 or 11*8.
        chk("reset_pdata", 2, 32'(ac_pd[2]), 32'h00);
        chk("reset_dv", 2, 32'(ac_dv[2]), 32'h0);
        chk("a5_dv", s1 + 82, 32'(ac_dv[s1 + 82]), 32'h1);
        chk("a5_pdata", s1 + 82, 32'(ac_pd[s1 + 82]), 32'hA5);
        chk("a5_dv_early", s1 + 81, 32'(ac_dv[s1 + 81]), 32'h0);
        chk("a5_dv_late", s1 + 83, 32'(ac_dv[s1 + 83]), 32'h0);
        chk("a5_errs", s1 + 82, 32'({ac_pe[s1 + 82], ac_se[s1 + 82]}), 32'h0);
        chk("0f_even_dv", s2 + 90, 32'(ac_dv[s2 + 90]), 32'h1);
        chk("0f_even_pdata", s2 + 90, 32'(ac_pd[s2 + 90]), 32'h0F);
        chk("0f_bad_par_err", s3 + 90, 32'(ac_pe[s3 + 90]), 32'h1);
        chk("0f_bad_par_dv", s3 + 90, 32'(ac_dv[s3 + 90]), 32'h0);
        chk("0f_bad_par_pdata", s3 + 90, 32'(ac_pd[s3 + 90]), 32'h0F);
        chk("3c_stp_err", s4 + 82, 32'(ac_se[s4 + 82]), 32'h1);
        chk("3c_stp_dv", s4 + 82, 32'(ac_dv[s4 + 82]), 32'h0);
        chk("3c_stp_pdata", s4 + 82, 32'(ac_pd[s4 + 82]), 32'h0F);
        chk("glitch_idle", g + 10, 32'(ac_st[g + 10]), 32'(ac_st[2]));
        chk("glitch_busy", g + 9, 32'(ac_st[g + 9] != ac_st[2]), 32'h1);
        chk("81_dv", s81 + 82, 32'(ac_dv[s81 + 82]), 32'h1);
        chk("81_pdata", s81 + 82, 32'(ac_pd[s81 + 82]), 32'h81);
        chk("midreset_pdata", s5 + 35, 32'(ac_pd[s5 + 35]), 32'h00);
        cnt = 0;
        for (int i = s5; i < s5 + 96; i++) cnt += int'(ac_dv[i]) + int'(ac_pe[i]) + int'(ac_se[i]);
        chk("midreset_strobes", s5, 32'(cnt), 32'h0);
        chk("after_reset_pdata", s6 + 82, 32'(ac_pd[s6 + 82]), 32'h3C);
        chk("b2b_55_dv", s7 + 90, 32'(ac_dv[s7 + 90]), 32'h1);
        chk("b2b_55_pdata", s7 + 90, 32'(ac_pd[s7 + 90]), 32'h55);
        chk("b2b_aa_dv", s7 + 178, 32'(ac_dv[s7 + 178]), 32'h1);
        chk("b2b_aa_pdata", s7 + 178, 32'(ac_pd[s7 + 178]), 32'hAA);
        chk("b2b_errs", s7 + 178, 32'({ac_pe[s7 + 90], ac_se[s7 + 90], ac_pe[s7 + 178], ac_se[s7 + 178]}), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
